ex_lsu_stage: RTL and testbench
===============================

# ex_lsu_stage

Combined execute and load/store block of the mini-rv single-issue pipeline, between decode (ID/EX operands) and register write-back. Computes ALU results, branch/jump decisions and memory addresses from decoded operands. Drives the data-memory request in the issue cycle and formats the load data returned one cycle later. The EX→WB and EX→IF outputs are registered; the memory request is combinational.

## Interface
- No parameters; widths are fixed to RV32I (XLEN 32, 5-bit register addresses).
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold all pipeline registers; suppress the memory request
- id_ex_instr_type  in  rv32i_instr_e  decoded instruction
- id_ex_rs1_data, id_ex_rs2_data  in  32  register operands
- id_ex_imm  in  32  sign-extended immediate
- id_ex_pc  in  32  instruction PC
- id_ex_rd_addr  in  5  destination register
- id_ex_write_en  in  1  instruction writes rd
- mem_wb_load_data  in  32  memory read data, valid the cycle after mem_read_en
- ex_if_take_branch  out  1  registered redirect request
- ex_if_branch_target  out  32  registered redirect PC
- ex_wb_result  out  32  registered ALU/address/link result
- ex_wb_write_en  out  1  registered rd write enable
- ex_wb_rd_addr  out  5  registered rd
- mem_addr  out  32  combinational rs1+imm
- mem_read_en, mem_write_en  out  1  combinational memory strobes
- store_size  out  2  00 byte, 01 half, 10 word
- store_data  out  32  lane-replicated store data
- wb_lsu_write_sel  out  1  registered: WB takes wb_load_result instead of ex_wb_result
- wb_load_result  out  32  formatted load data

## Operation
- ALU result: ADD/ADDI sum; SUB rs1−rs2; AND/OR/XOR(+I); SLL/SRL/SRA(+I) shift by low 5 bits of rs2/imm; SLT/SLTI signed, SLTU/SLTIU unsigned, result 0/1.
- LUI → imm. AUIPC → pc+imm. JAL → result pc+4, target pc+imm, taken. JALR → result pc+4, target (rs1+imm)&~1, taken.
- BEQ/BNE/BLT/BGE/BLTU/BGEU: compare rs1, rs2; target pc+imm; taken per condition; result is don't-care and 0 is driven.
- Loads/stores: result and mem_addr = rs1+imm. No alignment check; the address is passed through unmodified.
- mem_read_en = load & !stall. mem_write_en = store & !stall. Both are 0 otherwise.
- store_data: SB {4{rs2[7:0]}}, SH {2{rs2[15:0]}}, SW rs2. store_size follows the instruction type and is 00 for non-stores.
- Loads register the type and addr[1:0]. wb_load_result is combinational from mem_wb_load_data using the registered type and offset: LB/LBU select byte addr[1:0], sign/zero-extend; LH/LHU select half addr[1], extend; LW passes through.
- NOP and unknown types: result 0, write_en 0, no branch, no memory access.
- ex_wb_write_en and ex_wb_rd_addr copy id_ex_write_en and id_ex_rd_addr.

## Timing
- Every rising clk with !stall registers: result, write_en, rd_addr, take_branch, branch_target, wb_lsu_write_sel, load type/offset.
- stall=1: all registers hold their value. The memory request is suppressed and is reissued when stall releases.
- rst overrides stall. All registered outputs reset to 0, and the load type resets to none.
- Memory latency is 1 cycle. Load data is valid in the cycle wb_lsu_write_sel=1.

## Structure
- Package instruction_utils holds the rv32i_instr_e enum (INSTR_NOP, INSTR_ADD…INSTR_SW, all RV32I ops) plus the is_load/is_store/is_branch helper functions.
- Sub-modules: execute_stage (ALU, branch, EX/WB registers) and lsu (request generation, load formatting, wb_lsu_write_sel register).

## Test plan
- Reset, then NOP at pc 0x1000 → ex_wb_rd_addr=0, ex_wb_write_en=0.
- ADDI 10+5, rd1 → 15. ADD 20+30 → 50. SUB 100−40 → 60 (ignores imm 10).
- BEQ 50,50, imm 0x10, pc 0x1010 → take_branch=1, target 0x1020. BNE 50,50 → take_branch=0.
- LW rs1=0x2000, imm 8, load data 42 → same cycle: mem_addr 0x2008, read_en=1, write_en=0. Next edge: result 0x2008, wb_load_result 42.
- SW rs1=0xF0, imm 0xF, rs2=99 → mem_addr 0xFF, write_en=1, read_en=0, store_data 99. Next edge: result 0xFF, ex_wb_write_en=0.
- ADDI 1+1, rd5 with stall=1 → outputs still 0xFF/0. Release stall → result 2, write_en 1, rd 5.

Source files
------------

// File: rtl/instruction_utils.sv
// Shared RV32I instruction encoding for the execute/load-store slice,
// plus small classification helpers used by both sub-blocks.
package instruction_utils;

    typedef enum logic [5:0] {
        INSTR_NOP,
        INSTR_ADD, INSTR_SUB, INSTR_AND, INSTR_OR, INSTR_XOR,
        INSTR_SLL, INSTR_SRL, INSTR_SRA, INSTR_SLT, INSTR_SLTU,
        INSTR_ADDI, INSTR_ANDI, INSTR_ORI, INSTR_XORI,
        INSTR_SLLI, INSTR_SRLI, INSTR_SRAI, INSTR_SLTI, INSTR_SLTIU,
        INSTR_LUI, INSTR_AUIPC, INSTR_JAL, INSTR_JALR,
        INSTR_BEQ, INSTR_BNE, INSTR_BLT, INSTR_BGE, INSTR_BLTU, INSTR_BGEU,
        INSTR_LB, INSTR_LH, INSTR_LW, INSTR_LBU, INSTR_LHU,
        INSTR_SB, INSTR_SH, INSTR_SW
    } rv32i_instr_e;

    function automatic logic is_load(input rv32i_instr_e instr);
        return instr inside {INSTR_LB, INSTR_LH, INSTR_LW, INSTR_LBU, INSTR_LHU};
    endfunction

    function automatic logic is_store(input rv32i_instr_e instr);
        return instr inside {INSTR_SB, INSTR_SH, INSTR_SW};
    endfunction

    function automatic logic is_branch(input rv32i_instr_e instr);
        return instr inside {INSTR_BEQ, INSTR_BNE, INSTR_BLT,
                             INSTR_BGE, INSTR_BLTU, INSTR_BGEU};
    endfunction

endpackage

// File: rtl/execute_stage.sv
// ALU, branch resolution and the EX->WB / EX->IF pipeline registers.
// Also exposes the raw rs1+imm sum so the LSU can use it as the memory address.
module execute_stage
    import instruction_utils::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         stall_i,
    input  rv32i_instr_e instr_i,
    input  logic [31:0]  rs1_i,
    input  logic [31:0]  rs2_i,
    input  logic [31:0]  imm_i,
    input  logic [31:0]  pc_i,
    input  logic [4:0]   rd_addr_i,
    input  logic         write_en_i,
    output logic [31:0]  agen_o,
    output logic         take_branch_o,
    output logic [31:0]  branch_target_o,
    output logic [31:0]  result_o,
    output logic         write_en_o,
    output logic [4:0]   rd_addr_o
);

    logic [31:0] sum_ri;
    logic [31:0] pc_imm;
    logic [31:0] pc_plus4;
    logic [4:0]  shamt_r;
    logic [4:0]  shamt_i;

    logic [31:0] result_d, result_q;
    logic        take_d, take_q;
    logic [31:0] target_d, target_q;
    logic        write_en_d, write_en_q;
    logic [4:0]  rd_addr_q;

    assign sum_ri   = rs1_i + imm_i;
    assign pc_imm   = pc_i + imm_i;
    assign pc_plus4 = pc_i + 32'd4;
    assign shamt_r  = rs2_i[4:0];
    assign shamt_i  = imm_i[4:0];
    assign agen_o   = sum_ri;

    // Compute the next result, redirect decision and write enable for the instruction in EX.
    always_comb begin
        result_d   = '0;
        take_d     = 1'b0;
        target_d   = '0;
        write_en_d = write_en_i;
        case (instr_i)
            INSTR_ADD:   result_d = rs1_i + rs2_i;
            INSTR_SUB:   result_d = rs1_i - rs2_i;
            INSTR_AND:   result_d = rs1_i & rs2_i;
            INSTR_OR:    result_d = rs1_i | rs2_i;
            INSTR_XOR:   result_d = rs1_i ^ rs2_i;
            INSTR_SLL:   result_d = rs1_i << shamt_r;
            INSTR_SRL:   result_d = rs1_i >> shamt_r;
            INSTR_SRA:   result_d = $unsigned($signed(rs1_i) >>> shamt_r);
            INSTR_SLT:   result_d = {31'd0, $signed(rs1_i) < $signed(rs2_i)};
            INSTR_SLTU:  result_d = {31'd0, rs1_i < rs2_i};
            INSTR_ADDI:  result_d = sum_ri;
            INSTR_ANDI:  result_d = rs1_i & imm_i;
            INSTR_ORI:   result_d = rs1_i | imm_i;
            INSTR_XORI:  result_d = rs1_i ^ imm_i;
            INSTR_SLLI:  result_d = rs1_i << shamt_i;
            INSTR_SRLI:  result_d = rs1_i >> shamt_i;
            INSTR_SRAI:  result_d = $unsigned($signed(rs1_i) >>> shamt_i);
            INSTR_SLTI:  result_d = {31'd0, $signed(rs1_i) < $signed(imm_i)};
            INSTR_SLTIU: result_d = {31'd0, rs1_i < imm_i};
            INSTR_LUI:   result_d = imm_i;
            INSTR_AUIPC: result_d = pc_imm;
            INSTR_JAL: begin
                result_d = pc_plus4;
                take_d   = 1'b1;
                target_d = pc_imm;
            end
            INSTR_JALR: begin
                result_d = pc_plus4;
                take_d   = 1'b1;
                target_d = sum_ri & ~32'd1;
            end
            INSTR_BEQ:  begin target_d = pc_imm; take_d = (rs1_i == rs2_i); end
            INSTR_BNE:  begin target_d = pc_imm; take_d = (rs1_i != rs2_i); end
            INSTR_BLT:  begin target_d = pc_imm; take_d = ($signed(rs1_i) <  $signed(rs2_i)); end
            INSTR_BGE:  begin target_d = pc_imm; take_d = ($signed(rs1_i) >= $signed(rs2_i)); end
            INSTR_BLTU: begin target_d = pc_imm; take_d = (rs1_i <  rs2_i); end
            INSTR_BGEU: begin target_d = pc_imm; take_d = (rs1_i >= rs2_i); end
            INSTR_LB, INSTR_LH, INSTR_LW, INSTR_LBU, INSTR_LHU,
            INSTR_SB, INSTR_SH, INSTR_SW:
                         result_d = sum_ri;
            default:     write_en_d = 1'b0;
        endcase
    end

    // EX->WB and EX->IF registers: reset clears, stall holds, otherwise capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q   <= '0;
            take_q     <= 1'b0;
            target_q   <= '0;
            write_en_q <= 1'b0;
            rd_addr_q  <= '0;
        end else if (!stall_i) begin
            result_q   <= result_d;
            take_q     <= take_d;
            target_q   <= target_d;
            write_en_q <= write_en_d;
            rd_addr_q  <= rd_addr_i;
        end
    end

    assign result_o        = result_q;
    assign take_branch_o   = take_q;
    assign branch_target_o = target_q;
    assign write_en_o      = write_en_q;
    assign rd_addr_o       = rd_addr_q;

endmodule

// File: rtl/lsu.sv
// Load/store unit: drives the data-memory request in the issue cycle and
// formats the load data that returns one cycle later.
module lsu
    import instruction_utils::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         stall_i,
    input  rv32i_instr_e instr_i,
    input  logic [31:0]  addr_i,
    input  logic [31:0]  rs2_i,
    input  logic [31:0]  load_data_i,
    output logic [31:0]  mem_addr_o,
    output logic         mem_read_en_o,
    output logic         mem_write_en_o,
    output logic [1:0]   store_size_o,
    output logic [31:0]  store_data_o,
    output logic         write_sel_o,
    output logic [31:0]  load_result_o
);

    rv32i_instr_e load_type_q;
    logic [1:0]   offset_q;
    logic         write_sel_q;

    assign mem_addr_o = addr_i;

    // Memory strobes and lane-replicated store data for the instruction being issued.
    always_comb begin
        mem_read_en_o  = is_load(instr_i)  && !stall_i;
        mem_write_en_o = is_store(instr_i) && !stall_i;
        store_size_o   = 2'b00;
        store_data_o   = '0;
        case (instr_i)
            INSTR_SB: begin
                store_size_o = 2'b00;
                store_data_o = {4{rs2_i[7:0]}};
            end
            INSTR_SH: begin
                store_size_o = 2'b01;
                store_data_o = {2{rs2_i[15:0]}};
            end
            INSTR_SW: begin
                store_size_o = 2'b10;
                store_data_o = rs2_i;
            end
            default: ;
        endcase
    end

    // Remember the load flavour and byte offset so the returning data can be formatted.
    always_ff @(posedge clk) begin
        if (rst) begin
            load_type_q <= INSTR_NOP;
            offset_q    <= 2'b00;
            write_sel_q <= 1'b0;
        end else if (!stall_i) begin
            load_type_q <= is_load(instr_i) ? instr_i : INSTR_NOP;
            offset_q    <= addr_i[1:0];
            write_sel_q <= is_load(instr_i);
        end
    end

    logic [7:0]  load_byte;
    logic [15:0] load_half;

    // Pick the addressed byte/half from the returned word and extend it.
    always_comb begin
        load_byte     = '0;
        load_half     = offset_q[1] ? load_data_i[31:16] : load_data_i[15:0];
        load_result_o = '0;
        case (offset_q)
            2'd0: load_byte = load_data_i[7:0];
            2'd1: load_byte = load_data_i[15:8];
            2'd2: load_byte = load_data_i[23:16];
            2'd3: load_byte = load_data_i[31:24];
            default: ;
        endcase
        case (load_type_q)
            INSTR_LB:  load_result_o = {{24{load_byte[7]}}, load_byte};
            INSTR_LBU: load_result_o = {24'd0, load_byte};
            INSTR_LH:  load_result_o = {{16{load_half[15]}}, load_half};
            INSTR_LHU: load_result_o = {16'd0, load_half};
            INSTR_LW:  load_result_o = load_data_i;
            default: ;
        endcase
    end

    assign write_sel_o = write_sel_q;

endmodule

// File: rtl/ex_lsu_stage.sv
// Combined execute and load/store stage of the mini-rv pipeline: ties the
// execute datapath to the LSU and presents the pipeline-facing ports.
module ex_lsu_stage
    import instruction_utils::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         stall,
    input  rv32i_instr_e id_ex_instr_type,
    input  logic [31:0]  id_ex_rs1_data,
    input  logic [31:0]  id_ex_rs2_data,
    input  logic [31:0]  id_ex_imm,
    input  logic [31:0]  id_ex_pc,
    input  logic [4:0]   id_ex_rd_addr,
    input  logic         id_ex_write_en,
    input  logic [31:0]  mem_wb_load_data,
    output logic         ex_if_take_branch,
    output logic [31:0]  ex_if_branch_target,
    output logic [31:0]  ex_wb_result,
    output logic         ex_wb_write_en,
    output logic [4:0]   ex_wb_rd_addr,
    output logic [31:0]  mem_addr,
    output logic         mem_read_en,
    output logic         mem_write_en,
    output logic [1:0]   store_size,
    output logic [31:0]  store_data,
    output logic         wb_lsu_write_sel,
    output logic [31:0]  wb_load_result
);

    logic [31:0] agen;

    execute_stage u_execute (
        .clk             (clk),
        .rst             (rst),
        .stall_i         (stall),
        .instr_i         (id_ex_instr_type),
        .rs1_i           (id_ex_rs1_data),
        .rs2_i           (id_ex_rs2_data),
        .imm_i           (id_ex_imm),
        .pc_i            (id_ex_pc),
        .rd_addr_i       (id_ex_rd_addr),
        .write_en_i      (id_ex_write_en),
        .agen_o          (agen),
        .take_branch_o   (ex_if_take_branch),
        .branch_target_o (ex_if_branch_target),
        .result_o        (ex_wb_result),
        .write_en_o      (ex_wb_write_en),
        .rd_addr_o       (ex_wb_rd_addr)
    );

    lsu u_lsu (
        .clk            (clk),
        .rst            (rst),
        .stall_i        (stall),
        .instr_i        (id_ex_instr_type),
        .addr_i         (agen),
        .rs2_i          (id_ex_rs2_data),
        .load_data_i    (mem_wb_load_data),
        .mem_addr_o     (mem_addr),
        .mem_read_en_o  (mem_read_en),
        .mem_write_en_o (mem_write_en),
        .store_size_o   (store_size),
        .store_data_o   (store_data),
        .write_sel_o    (wb_lsu_write_sel),
        .load_result_o  (wb_load_result)
    );

endmodule

// File: tb/tb_ex_lsu_stage.sv
// Directed self-checking bench for ex_lsu_stage.
module tb_ex_lsu_stage;
    import instruction_utils::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         stall;
    rv32i_instr_e id_ex_instr_type;
    logic [31:0]  id_ex_rs1_data;
    logic [31:0]  id_ex_rs2_data;
    logic [31:0]  id_ex_imm;
    logic [31:0]  id_ex_pc;
    logic [4:0]   id_ex_rd_addr;
    logic         id_ex_write_en;
    logic [31:0]  mem_wb_load_data;
    logic         ex_if_take_branch;
    logic [31:0]  ex_if_branch_target;
    logic [31:0]  ex_wb_result;
    logic         ex_wb_write_en;
    logic [4:0]   ex_wb_rd_addr;
    logic [31:0]  mem_addr;
    logic         mem_read_en;
    logic         mem_write_en;
    logic [1:0]   store_size;
    logic [31:0]  store_data;
    logic         wb_lsu_write_sel;
    logic [31:0]  wb_load_result;

    int checkCount = 0;
    int failCount  = 0;

    ex_lsu_stage dut (
        .clk                 (clk),
        .rst                 (rst),
        .stall               (stall),
        .id_ex_instr_type    (id_ex_instr_type),
        .id_ex_rs1_data      (id_ex_rs1_data),
        .id_ex_rs2_data      (id_ex_rs2_data),
        .id_ex_imm           (id_ex_imm),
        .id_ex_pc            (id_ex_pc),
        .id_ex_rd_addr       (id_ex_rd_addr),
        .id_ex_write_en      (id_ex_write_en),
        .mem_wb_load_data    (mem_wb_load_data),
        .ex_if_take_branch   (ex_if_take_branch),
        .ex_if_branch_target (ex_if_branch_target),
        .ex_wb_result        (ex_wb_result),
        .ex_wb_write_en      (ex_wb_write_en),
        .ex_wb_rd_addr       (ex_wb_rd_addr),
        .mem_addr            (mem_addr),
        .mem_read_en         (mem_read_en),
        .mem_write_en        (mem_write_en),
        .store_size          (store_size),
        .store_data          (store_data),
        .wb_lsu_write_sel    (wb_lsu_write_sel),
        .wb_load_result      (wb_load_result)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    // Present one decoded instruction at the falling edge.
    task automatic drive_instr(input rv32i_instr_e t, input logic [31:0] rs1,
                               input logic [31:0] rs2, input logic [31:0] imm,
                               input logic [31:0] pc, input logic [4:0] rd,
                               input logic we);
        @(negedge clk);
        id_ex_instr_type = t;
        id_ex_rs1_data   = rs1;
        id_ex_rs2_data   = rs2;
        id_ex_imm        = imm;
        id_ex_pc         = pc;
        id_ex_rd_addr    = rd;
        id_ex_write_en   = we;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        stall = 1'b0;
        mem_wb_load_data = 32'hDEAD_BEEF;
        drive_instr(INSTR_ADDI, 32'd7, 32'd0, 32'd1, 32'h0, 5'd3, 1'b1);
        step();
        step();
        checkCount++;
        if (ex_wb_result !== 32'd0 || ex_wb_write_en !== 1'b0 || ex_wb_rd_addr !== 5'd0) begin
            failCount++;
            $display("[TB] FAIL reset_wb got=%h/%b/%0d exp=0/0/0", ex_wb_result, ex_wb_write_en, ex_wb_rd_addr);
        end
        checkCount++;
        if (ex_if_take_branch !== 1'b0 || ex_if_branch_target !== 32'd0 || wb_lsu_write_sel !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL reset_branch_sel got=%b/%h/%b exp=0/0/0", ex_if_take_branch, ex_if_branch_target, wb_lsu_write_sel);
        end
        checkCount++;
        if (wb_load_result !== 32'd0) begin
            failCount++;
            $display("[TB] FAIL reset_load_result got=%h exp=0", wb_load_result);
        end
        rst = 1'b0;
        drive_instr(INSTR_NOP, 32'd0, 32'd0, 32'd0, 32'h1000, 5'd0, 1'b0);
        step();
        checkCount++;
        if (ex_wb_rd_addr !== 5'd0 || ex_wb_write_en !== 1'b0 || ex_wb_result !== 32'd0) begin
            failCount++;
            $display("[TB] FAIL nop got=%0d/%b/%h exp=0/0/0", ex_wb_rd_addr, ex_wb_write_en, ex_wb_result);
        end
    endtask

    task automatic test_alu();
        rv32i_instr_e types[10] = '{INSTR_ADDI, INSTR_ADD, INSTR_SUB, INSTR_SLT, INSTR_SLTU,
                                    INSTR_SRA, INSTR_SRAI, INSTR_XORI, INSTR_LUI, INSTR_AUIPC};
        logic [31:0] rs1s[10] = '{32'd10, 32'd20, 32'd100, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                  32'h8000_0000, 32'h8000_0000, 32'h0000_00F0, 32'd0, 32'd0};
        logic [31:0] rs2s[10] = '{32'd0, 32'd30, 32'd40, 32'd1, 32'd1,
                                  32'd4, 32'd31, 32'd0, 32'd0, 32'd0};
        logic [31:0] imms[10] = '{32'd5, 32'd0, 32'd10, 32'd0, 32'd0,
                                  32'd0, 32'd8, 32'h0000_0FFF, 32'hABCD_E000, 32'h0000_2000};
        logic [31:0] exps[10] = '{32'd15, 32'd50, 32'd60, 32'd1, 32'd0,
                                  32'hF800_0000, 32'hFF80_0000, 32'h0000_0F0F, 32'hABCD_E000, 32'h0000_3000};
        for (int i = 0; i < 10; i++) begin
            drive_instr(types[i], rs1s[i], rs2s[i], imms[i], 32'h1000, 5'd1, 1'b1);
            step();
            checkCount++;
            if (ex_wb_result !== exps[i] || ex_wb_write_en !== 1'b1 || ex_wb_rd_addr !== 5'd1) begin
                failCount++;
                $display("[TB] FAIL alu_%s got=%h/%b/%0d exp=%h/1/1", types[i].name(), ex_wb_result,
                         ex_wb_write_en, ex_wb_rd_addr, exps[i]);
            end
        end
    endtask

    task automatic test_branch();
        drive_instr(INSTR_BEQ, 32'd50, 32'd50, 32'h10, 32'h1010, 5'd0, 1'b0);
        step();
        checkCount++;
        if (ex_if_take_branch !== 1'b1 || ex_if_branch_target !== 32'h1020 || ex_wb_result !== 32'd0) begin
            failCount++;
            $display("[TB] FAIL beq got=%b/%h/%h exp=1/00001020/0", ex_if_take_branch, ex_if_branch_target, ex_wb_result);
        end
        drive_instr(INSTR_BNE, 32'd50, 32'd50, 32'h10, 32'h1010, 5'd0, 1'b0);
        step();
        checkCount++;
        if (ex_if_take_branch !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL bne got=%b exp=0", ex_if_take_branch);
        end
        drive_instr(INSTR_BLT, 32'hFFFF_FFFE, 32'd1, 32'h8, 32'h2000, 5'd0, 1'b0);
        step();
        checkCount++;
        if (ex_if_take_branch !== 1'b1 || ex_if_branch_target !== 32'h2008) begin
            failCount++;
            $display("[TB] FAIL blt got=%b/%h exp=1/00002008", ex_if_take_branch, ex_if_branch_target);
        end
        drive_instr(INSTR_BLTU, 32'hFFFF_FFFE, 32'd1, 32'h8, 32'h2000, 5'd0, 1'b0);
        step();
        checkCount++;
        if (ex_if_take_branch !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL bltu got=%b exp=0", ex_if_take_branch);
        end
        drive_instr(INSTR_JAL, 32'd0, 32'd0, 32'h20, 32'h100, 5'd1, 1'b1);
        step();
        checkCount++;
        if (ex_if_take_branch !== 1'b1 || ex_if_branch_target !== 32'h120 || ex_wb_result !== 32'h104) begin
            failCount++;
            $display("[TB] FAIL jal got=%b/%h/%h exp=1/00000120/00000104", ex_if_take_branch, ex_if_branch_target, ex_wb_result);
        end
        drive_instr(INSTR_JALR, 32'h203, 32'd0, 32'h4, 32'h300, 5'd1, 1'b1);
        step();
        checkCount++;
        if (ex_if_take_branch !== 1'b1 || ex_if_branch_target !== 32'h206 || ex_wb_result !== 32'h304) begin
            failCount++;
            $display("[TB] FAIL jalr got=%b/%h/%h exp=1/00000206/00000304", ex_if_take_branch, ex_if_branch_target, ex_wb_result);
        end
    endtask

    task automatic test_load();
        rv32i_instr_e types[4] = '{INSTR_LB, INSTR_LBU, INSTR_LH, INSTR_LHU};
        logic [31:0] offs[4] = '{32'd1, 32'd3, 32'd2, 32'd0};
        logic [31:0] exps[4] = '{32'hFFFF_FFF2, 32'h0000_0080, 32'hFFFF_8081, 32'h0000_F2A3};
        drive_instr(INSTR_LW, 32'h2000, 32'd0, 32'd8, 32'h1000, 5'd2, 1'b1);
        mem_wb_load_data = 32'd42;
        #1;
        checkCount++;
        if (mem_addr !== 32'h2008 || mem_read_en !== 1'b1 || mem_write_en !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL lw_request got=%h/%b/%b exp=00002008/1/0", mem_addr, mem_read_en, mem_write_en);
        end
        step();
        checkCount++;
        if (ex_wb_result !== 32'h2008 || wb_lsu_write_sel !== 1'b1 || wb_load_result !== 32'd42) begin
            failCount++;
            $display("[TB] FAIL lw_result got=%h/%b/%h exp=00002008/1/0000002a", ex_wb_result, wb_lsu_write_sel, wb_load_result);
        end
        mem_wb_load_data = 32'h8081_F2A3;
        for (int i = 0; i < 4; i++) begin
            drive_instr(types[i], 32'h3000, 32'd0, offs[i], 32'h1000, 5'd2, 1'b1);
            step();
            checkCount++;
            if (wb_load_result !== exps[i] || wb_lsu_write_sel !== 1'b1) begin
                failCount++;
                $display("[TB] FAIL load_%s got=%h/%b exp=%h/1", types[i].name(), wb_load_result, wb_lsu_write_sel, exps[i]);
            end
        end
    endtask

    task automatic test_store();
        drive_instr(INSTR_SB, 32'h10, 32'h1234_56AB, 32'd0, 32'h1000, 5'd0, 1'b0);
        #1;
        checkCount++;
        if (store_data !== 32'hABAB_ABAB || store_size !== 2'b00 || mem_write_en !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL sb got=%h/%b/%b exp=abababab/00/1", store_data, store_size, mem_write_en);
        end
        drive_instr(INSTR_SH, 32'h10, 32'h1234_56AB, 32'd0, 32'h1000, 5'd0, 1'b0);
        #1;
        checkCount++;
        if (store_data !== 32'h56AB_56AB || store_size !== 2'b01) begin
            failCount++;
            $display("[TB] FAIL sh got=%h/%b exp=56ab56ab/01", store_data, store_size);
        end
        drive_instr(INSTR_SW, 32'hF0, 32'd99, 32'hF, 32'h1000, 5'd0, 1'b0);
        #1;
        checkCount++;
        if (mem_addr !== 32'hFF || mem_write_en !== 1'b1 || mem_read_en !== 1'b0 ||
            store_data !== 32'd99 || store_size !== 2'b10) begin
            failCount++;
            $display("[TB] FAIL sw_request got=%h/%b/%b/%h/%b exp=000000ff/1/0/00000063/10",
                     mem_addr, mem_write_en, mem_read_en, store_data, store_size);
        end
        step();
        checkCount++;
        if (ex_wb_result !== 32'hFF || ex_wb_write_en !== 1'b0 || wb_lsu_write_sel !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL sw_result got=%h/%b/%b exp=000000ff/0/0", ex_wb_result, ex_wb_write_en, wb_lsu_write_sel);
        end
    endtask

    task automatic test_stall();
        drive_instr(INSTR_ADDI, 32'd1, 32'd0, 32'd1, 32'h1000, 5'd5, 1'b1);
        stall = 1'b1;
        step();
        checkCount++;
        if (ex_wb_result !== 32'hFF || ex_wb_write_en !== 1'b0 || ex_wb_rd_addr !== 5'd0) begin
            failCount++;
            $display("[TB] FAIL stall_hold got=%h/%b/%0d exp=000000ff/0/0", ex_wb_result, ex_wb_write_en, ex_wb_rd_addr);
        end
        @(negedge clk);
        stall = 1'b0;
        step();
        checkCount++;
        if (ex_wb_result !== 32'd2 || ex_wb_write_en !== 1'b1 || ex_wb_rd_addr !== 5'd5) begin
            failCount++;
            $display("[TB] FAIL stall_release got=%h/%b/%0d exp=2/1/5", ex_wb_result, ex_wb_write_en, ex_wb_rd_addr);
        end
        drive_instr(INSTR_LW, 32'h400, 32'd0, 32'd4, 32'h1000, 5'd6, 1'b1);
        stall = 1'b1;
        #1;
        checkCount++;
        if (mem_read_en !== 1'b0 || mem_write_en !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL stall_suppress got=%b/%b exp=0/0", mem_read_en, mem_write_en);
        end
        step();
        checkCount++;
        if (wb_lsu_write_sel !== 1'b0 || ex_wb_result !== 32'd2) begin
            failCount++;
            $display("[TB] FAIL stall_load_hold got=%b/%h exp=0/2", wb_lsu_write_sel, ex_wb_result);
        end
        @(negedge clk);
        stall = 1'b0;
        #1;
        checkCount++;
        if (mem_read_en !== 1'b1 || mem_addr !== 32'h404) begin
            failCount++;
            $display("[TB] FAIL stall_reissue got=%b/%h exp=1/00000404", mem_read_en, mem_addr);
        end
        step();
        checkCount++;
        if (wb_lsu_write_sel !== 1'b1 || ex_wb_result !== 32'h404) begin
            failCount++;
            $display("[TB] FAIL stall_load_done got=%b/%h exp=1/00000404", wb_lsu_write_sel, ex_wb_result);
        end
        @(negedge clk);
        stall = 1'b1;
        rst = 1'b1;
        step();
        checkCount++;
        if (ex_wb_result !== 32'd0 || wb_lsu_write_sel !== 1'b0 || ex_wb_write_en !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL reset_over_stall got=%h/%b/%b exp=0/0/0", ex_wb_result, wb_lsu_write_sel, ex_wb_write_en);
        end
        @(negedge clk);
        rst = 1'b0;
        stall = 1'b0;
    endtask

    // Run every scenario in order, then report.
    initial begin
        test_reset();
        test_alu();
        test_branch();
        test_load();
        test_store();
        test_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
